// File: rtl/wheel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wheel_pkg
// Purpose  : Shared types and sizing helpers for the wheel direction decoder
//            and the downstream bogey counter.
// Revision : 1.0 - initial release
// ============================================================================
package wheel_pkg;

  // Pattern FSM states over the filtered sensor pair {fa, fb}
  typedef enum logic [2:0] {
    IDLE   = 3'd0,  // 00
    S_A    = 3'd1,  // 10
    S_AB   = 3'd2,  // 11
    S_B    = 3'd3,  // 01
    RESYNC = 3'd4   // after an illegal jump, waiting for 00
  } wheel_state_e;

  // Side through which the wheel entered the sensor pair
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SIDE_A = 2'd1,
    SIDE_B = 2'd2
  } entry_side_e;

  // Bits needed to hold the value max_val (at least one bit)
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;
  localparam int STUCK_CYCLES_DEFAULT    = 1000;
  localparam int DEBOUNCE_CYCLES_MAX     = 255;
  localparam int STUCK_CYCLES_MAX        = (1 << 20) - 1;

  localparam int DEBOUNCE_CNT_W     = cnt_width(DEBOUNCE_CYCLES_DEFAULT);
  localparam int STUCK_CNT_W        = cnt_width(STUCK_CYCLES_DEFAULT);
  localparam int DEBOUNCE_CNT_W_MAX = cnt_width(DEBOUNCE_CYCLES_MAX);
  localparam int STUCK_CNT_W_MAX    = cnt_width(STUCK_CYCLES_MAX);

endpackage
`default_nettype wire

// File: rtl/wheel_direction_decoder_sensor_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sensor_debounce
// Purpose  : Two-flop synchroniser followed by a hold-time debounce filter
//            for one raw track-side wheel sensor.
// Revision : 1.0 - initial release
// ============================================================================
module sensor_debounce
  import wheel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic raw,
  output logic filt
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  // The counter "reaches" DEBOUNCE_CYCLES on the cycle it would step past
  // this value, which is when the filtered value is updated.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous sensor into the Clk domain
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (sync2 == filt) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      filt <= sync2;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wheel_direction_decoder.sv
`default_nettype none
// ============================================================================
// Module   : wheel_direction_decoder
// Purpose  : Turns two raw wheel sensors (A then B along the track) into
//            single-cycle a2b / b2a wheel-passage pulses, with illegal-jump
//            error pulses and a stuck indicator.
// Revision : 1.0 - initial release
// ============================================================================
module wheel_direction_decoder
  import wheel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STUCK_CYCLES    = 1000
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic sens_a,
  input  logic sens_b,
  output logic a2b,
  output logic b2a,
  output logic err,
  output logic stuck
);

  localparam int                 STUCK_W   = cnt_width(STUCK_CYCLES);
  localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_CYCLES);

  logic               fa;
  logic               fb;
  logic [1:0]         pair;

  wheel_state_e       state;
  wheel_state_e       next_state;
  entry_side_e        entry;
  entry_side_e        next_entry;
  logic               next_a2b;
  logic               next_b2a;
  logic               next_err;
  logic [STUCK_W-1:0] stuck_cnt;
  logic [STUCK_W-1:0] next_stuck_cnt;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_a (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .raw    (sens_a),
    .filt   (fa)
  );

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_b (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .raw    (sens_b),
    .filt   (fb)
  );

  assign pair = {fa, fb};

  // Pattern decode: neighbour moves are legal, a two-bit jump is an error
  always_comb begin
    next_state = state;
    next_entry = entry;
    next_a2b   = 1'b0;
    next_b2a   = 1'b0;
    next_err   = 1'b0;
    case (state)
      IDLE: begin
        case (pair)
          2'b10: begin next_state = S_A; next_entry = SIDE_A; end
          2'b01: begin next_state = S_B; next_entry = SIDE_B; end
          2'b11: begin next_state = RESYNC; next_err = 1'b1; end
          default: ;
        endcase
      end
      S_A: begin
        case (pair)
          2'b00: begin
            next_state = IDLE;
            next_entry = NONE;
            next_b2a   = (entry == SIDE_B);
          end
          2'b11: next_state = S_AB;
          2'b01: begin next_state = RESYNC; next_entry = NONE; next_err = 1'b1; end
          default: ;
        endcase
      end
      S_AB: begin
        case (pair)
          2'b10: next_state = S_A;
          2'b01: next_state = S_B;
          2'b00: begin next_state = RESYNC; next_entry = NONE; next_err = 1'b1; end
          default: ;
        endcase
      end
      S_B: begin
        case (pair)
          2'b00: begin
            next_state = IDLE;
            next_entry = NONE;
            next_a2b   = (entry == SIDE_A);
          end
          2'b11: next_state = S_AB;
          2'b10: begin next_state = RESYNC; next_entry = NONE; next_err = 1'b1; end
          default: ;
        endcase
      end
      RESYNC: begin
        // Only a clean 00 re-arms the decoder
        if (pair == 2'b00) begin
          next_state = IDLE;
          next_entry = NONE;
        end
      end
      default: begin
        next_state = RESYNC;
        next_entry = NONE;
      end
    endcase
  end

  // Time spent away from IDLE, saturating; cleared as IDLE is entered
  always_comb begin
    next_stuck_cnt = stuck_cnt;
    if (next_state == IDLE) begin
      next_stuck_cnt = '0;
    end else if ((state != IDLE) && (stuck_cnt != STUCK_MAX)) begin
      next_stuck_cnt = stuck_cnt + 1'b1;
    end
  end

  // Register FSM state and all outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      entry     <= NONE;
      a2b       <= 1'b0;
      b2a       <= 1'b0;
      err       <= 1'b0;
      stuck_cnt <= '0;
      stuck     <= 1'b0;
    end else begin
      state     <= next_state;
      entry     <= next_entry;
      a2b       <= next_a2b;
      b2a       <= next_b2a;
      err       <= next_err;
      stuck_cnt <= next_stuck_cnt;
      stuck     <= (next_stuck_cnt == STUCK_MAX);
    end
  end

endmodule
`default_nettype wire
